// File: rtl/wb_uart_master.sv
// rtl/wb_uart_master.sv - Wishbone initiator driven by a UART byte-stream command protocol
// Frames: cmd, addr[4] MSB first, (write) data[4] MSB first; replies status (+4 read bytes).
module wb_uart_master #(
  parameter logic [7:0]  CMD_WR  = 8'h57,
  parameter logic [7:0]  CMD_RD  = 8'h52,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

  localparam logic [7:0]  STAT_OK  = 8'h4B;
  localparam logic [7:0]  STAT_ERR = 8'h45;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [15:0] tmo_cnt;
  logic [31:0] rd_shift;
  logic [2:0]  resp_left;
  logic        cyc_q;

  // A single register drives both strobes, so stb_o can never appear without cyc_o.
  assign cyc_o = cyc_q;
  assign stb_o = cyc_q;
  assign sel_o = 4'hF;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      byte_cnt  <= 2'd0;
      tmo_cnt   <= 16'd0;
      rd_shift  <= 32'd0;
      resp_left <= 3'd0;
      cyc_q     <= 1'b0;
      adr_o     <= 32'd0;
      dat_o     <= 32'd0;
      we_o      <= 1'b0;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
            we_o     <= (rx_data == CMD_WR);
            byte_cnt <= 2'd0;
            busy_o   <= 1'b1;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            adr_o    <= {adr_o[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (we_o) begin
                state <= ST_DATA;
              end else begin
                cyc_q   <= 1'b1;
                tmo_cnt <= 16'd0;
                state   <= ST_BUS;
              end
            end
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            dat_o    <= {dat_o[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              cyc_q   <= 1'b1;
              tmo_cnt <= 16'd0;
              state   <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          // ack wins over the timeout when both land on the last allowed cycle.
          if (ack_i) begin
            cyc_q     <= 1'b0;
            if (!we_o) rd_shift <= dat_i;
            tx_data   <= STAT_OK;
            tx_valid  <= 1'b1;
            resp_left <= we_o ? 3'd0 : 3'd4;
            state     <= ST_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            cyc_q     <= 1'b0;
            rd_shift  <= 32'd0;
            tx_data   <= STAT_ERR;
            tx_valid  <= 1'b1;
            resp_left <= we_o ? 3'd0 : 3'd4;
            state     <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          if (tx_ready) begin
            if (resp_left == 3'd0) begin
              tx_valid <= 1'b0;
              busy_o   <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              tx_data   <= rd_shift[31:24];
              rd_shift  <= {rd_shift[23:0], 8'h00};
              resp_left <= resp_left - 3'd1;
            end
          end
        end
        default: begin
          cyc_q    <= 1'b0;
          tx_valid <= 1'b0;
          busy_o   <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_uart_master.sv
// tb/tb_wb_uart_master.sv - bench for wb_uart_master: frame-level model, per-cycle compare, directed frames
module tb_wb_uart_master;
  localparam int TMO = 255;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] adr_o, dat_o, dat_i;
  logic        we_o, cyc_o, stb_o, busy_o;
  logic [3:0]  sel_o;
  logic        ack_i = 1'b0;

  wb_uart_master #(.TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: one expected bus cycle and a byte list per complete frame.
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [15:0] len;
  } cyc_t;

  cyc_t       exp_cyc[$];
  logic [7:0] exp_tx[$];
  logic [7:0] got_tx[$];
  int         n_cyc_seen = 0;

  int          ack_delay = -1;
  logic [31:0] rdata = 32'd0;
  int          wait_cnt = 0;
  assign dat_i = rdata;

  // Slave: ack_delay counts stb cycles before ack; -1 never acks.
  always @(negedge clk_i) begin
    if (stb_o) begin
      ack_i = (wait_cnt == ack_delay);
      wait_cnt++;
    end else begin
      ack_i = 1'b0;
      wait_cnt = 0;
    end
  end

  cyc_t       cur;
  int         cur_len = 0;
  logic       prev_cyc = 1'b0, prev_txv = 1'b0, prev_hs = 1'b0;
  logic [7:0] prev_txd = 8'd0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_cyc = 1'b0; prev_txv = 1'b0; prev_hs = 1'b0; cur_len = 0;
    end else begin
      if (stb_o) chk("stb implies cyc", cyc_o, 1'b1);
      if (cyc_o && !prev_cyc) begin
        n_cyc_seen++;
        cur_len = 1;
        chk("wb cycle expected", exp_cyc.size() != 0, 1'b1);
        if (exp_cyc.size() != 0) begin
          cur = exp_cyc.pop_front();
          chk("wb adr", adr_o, cur.adr);
          chk("wb we", we_o, cur.we);
          chk("wb sel", sel_o, 4'hF);
          if (cur.we) chk("wb dat", dat_o, cur.dat);
        end
      end else if (cyc_o) begin
        cur_len++;
      end else if (prev_cyc) begin
        chk("wb cycle length", cur_len, 32'(cur.len));
      end
      if (prev_txv && !prev_hs) begin
        chk("tx_valid held", tx_valid, 1'b1);
        chk("tx_data stable", tx_data, prev_txd);
      end
      if (tx_valid && tx_ready) begin
        got_tx.push_back(tx_data);
        chk("tx byte expected", exp_tx.size() != 0, 1'b1);
        if (exp_tx.size() != 0) chk("tx byte", tx_data, exp_tx.pop_front());
      end
      prev_cyc = cyc_o;
      prev_txv = tx_valid;
      prev_hs  = tx_valid && tx_ready;
      prev_txd = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_i); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk_i); #1;
    rx_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat,
                             input int delay, input logic [31:0] rd);
    logic        wr, ok;
    logic [31:0] rv;
    wr = (cmd == 8'h57);
    ok = (delay >= 0) && (delay < TMO);
    rv = ok ? rd : 32'd0;
    ack_delay = delay;
    rdata = rd;
    exp_cyc.push_back('{adr, dat, wr, ok ? 16'(delay + 1) : 16'(TMO)});
    exp_tx.push_back(ok ? 8'h4B : 8'h45);
    if (!wr) for (int i = 0; i < 4; i++) exp_tx.push_back(rv[31-8*i -: 8]);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(adr[31-8*i -: 8]);
    if (wr) for (int i = 0; i < 4; i++) send_byte(dat[31-8*i -: 8]);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < TMO + 300; i++) begin
      @(posedge clk_i); #1;
      if (!busy_o) break;
    end
    chk({name, " idle"}, busy_o, 1'b0);
    chk({name, " tx drained"}, exp_tx.size(), 0);
  endtask

  logic [7:0] lit_rd[5]  = '{8'h4B, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [7:0] lit_rto[5] = '{8'h45, 8'h00, 8'h00, 8'h00, 8'h00};
  int n0, c0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; tx_ready = 1'b1;
    #1;
    chk("reset adr_o", adr_o, 32'd0);
    chk("reset dat_o", dat_o, 32'd0);
    chk("reset tx_data", tx_data, 8'd0);
    chk("reset ctrl", {we_o, cyc_o, stb_o, tx_valid, busy_o}, 5'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Write, ack one cycle after stb.
    n0 = got_tx.size(); c0 = n_cyc_seen;
    start_frame(8'h57, 32'h0000_0800, 32'h0000_0041, 1, 32'd0);
    wait_done("write ack");
    chk("write cycles", n_cyc_seen - c0, 1);
    chk("write tx count", got_tx.size() - n0, 1);
    if (got_tx.size() > n0) chk("write status", got_tx[n0], 8'h4B);

    // Read, ack after three wait cycles.
    n0 = got_tx.size();
    start_frame(8'h52, 32'h0000_0800, 32'd0, 3, 32'hDEAD_BEEF);
    wait_done("read ack");
    chk("read tx count", got_tx.size() - n0, 5);
    for (int i = 0; i < 5; i++)
      if (got_tx.size() > n0 + i) chk("read literal byte", got_tx[n0+i], lit_rd[i]);

    // Write timeout.
    n0 = got_tx.size();
    start_frame(8'h57, 32'hFFFF_0000, 32'h1234_5678, -1, 32'd0);
    wait_done("write timeout");
    if (got_tx.size() > n0) chk("write timeout status", got_tx[n0], 8'h45);

    // Read timeout.
    n0 = got_tx.size();
    start_frame(8'h52, 32'hFFFF_0004, 32'd0, -1, 32'hCAFE_F00D);
    wait_done("read timeout");
    chk("read timeout tx count", got_tx.size() - n0, 5);
    for (int i = 0; i < 5; i++)
      if (got_tx.size() > n0 + i) chk("read timeout literal byte", got_tx[n0+i], lit_rto[i]);

    // Ack on the very last allowed cycle still succeeds.
    n0 = got_tx.size();
    start_frame(8'h52, 32'h0000_0010, 32'd0, TMO - 1, 32'h1234_5678);
    wait_done("late ack");
    if (got_tx.size() > n0) chk("late ack status", got_tx[n0], 8'h4B);

    // Noise in IDLE, then a read with noise during BUS and a stalled RESP.
    send_byte(8'h33);
    repeat (2) @(posedge clk_i); #1;
    chk("noise idle busy", busy_o, 1'b0);
    tx_ready = 1'b0;
    c0 = n_cyc_seen;
    start_frame(8'h52, 32'h0000_0020, 32'd0, 10, 32'hA5C3_0F1E);
    for (int i = 0; i < 50 && !cyc_o; i++) begin @(posedge clk_i); #1; end
    chk("noise bus reached", cyc_o, 1'b1);
    send_byte(8'h57);
    send_byte(8'h52);
    for (int i = 0; i < 50 && !tx_valid; i++) begin @(posedge clk_i); #1; end
    chk("stall tx_valid", tx_valid, 1'b1);
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (16) @(posedge clk_i);
    #1 tx_ready = 1'b1;
    wait_done("stalled read");
    chk("noise cycles", n_cyc_seen - c0, 1);
    start_frame(8'h57, 32'h0000_0030, 32'h0BAD_F00D, 0, 32'd0);
    wait_done("post noise write");

    // Reset after two address bytes, then a clean write.
    send_byte(8'h57);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("mid frame busy", busy_o, 1'b1);
    @(posedge clk_i); #3 rst_i = 1'b1;
    #1;
    chk("async reset adr_o", adr_o, 32'd0);
    chk("async reset ctrl", {we_o, cyc_o, stb_o, tx_valid, busy_o}, 5'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    n0 = got_tx.size(); c0 = n_cyc_seen;
    start_frame(8'h57, 32'h0000_0040, 32'h0000_00FF, 2, 32'd0);
    wait_done("after reset write");
    chk("after reset cycles", n_cyc_seen - c0, 1);
    chk("after reset tx count", got_tx.size() - n0, 1);
    if (got_tx.size() > n0) chk("after reset status", got_tx[n0], 8'h4B);

    repeat (5) @(posedge clk_i); #1;
    chk("all cycles seen", exp_cyc.size(), 0);
    chk("all tx seen", exp_tx.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_uart_master.md
Name: wb_uart_master

Overview:
- Wishbone initiator driven by a byte stream from the UART receive side.
- Decodes a fixed binary command protocol (write / read, 32-bit address, 32-bit data) and runs one classic single Wishbone cycle per command.
- Returns status and read data as a byte stream toward the UART transmit side.
- Sits between uart_ctl byte outputs and the system Wishbone interconnect, giving host debug access to peripherals such as ioctrl_wb.

Parameters:
- CMD_WR, 8'h57, command byte for a write ('W').
- CMD_RD, 8'h52, command byte for a read ('R').
- TIMEOUT, 255, cycles to wait for ack_i after stb_o rises before aborting; range 1..65535.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid in that cycle.
- tx_data  out  8  response byte.
- tx_valid  out  1  response byte available.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid & tx_ready at a rising edge.
- adr_o  out  32  Wishbone address.
- dat_o  out  32  Wishbone write data.
- dat_i  in  32  Wishbone read data.
- we_o  out  1  write enable.
- sel_o  out  4  byte selects; constant 4'hF.
- cyc_o  out  1  cycle.
- stb_o  out  1  strobe.
- ack_i  in  1  acknowledge.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_i, asynchronous, active-high; clock clk_i): state IDLE. adr_o, dat_o, tx_data = 0. we_o, cyc_o, stb_o, tx_valid, busy_o = 0. Internal counters = 0. Reset mid-command or mid-cycle aborts immediately; no response byte is produced.
- Frame format: command byte, then address (4 bytes, MSB first), then for writes data (4 bytes, MSB first).
- Response format:
  - Write: 1 status byte.
  - Read: status byte, then 4 data bytes MSB first.
  - Status byte: 8'h4B ('K') if ack received; 8'h45 ('E') on timeout. Read data bytes after a timeout are 8'h00.
- IDLE: on rx_valid with rx_data == CMD_WR or CMD_RD, latch we_o = (rx_data == CMD_WR), clear byte counter, go to ADDR. Any other byte is ignored.
- ADDR: on each rx_valid, adr_o <= {adr_o[23:0], rx_data}. After the 4th byte: writes go to DATA, reads go to BUS.
- DATA: on each rx_valid, dat_o <= {dat_o[23:0], rx_data}. After the 4th byte go to BUS.
- No inter-byte timeout: the state machine waits indefinitely for the next byte.
- BUS:
  - cyc_o = stb_o = 1 from the first cycle in BUS; timeout counter cleared on entry.
  - On ack_i: deassert cyc_o/stb_o at that edge, capture dat_i into the read shift register when reading, set status K, go to RESP.
  - If ack_i is not seen within TIMEOUT cycles: deassert cyc_o/stb_o, status E, read data 0, go to RESP.
  - ack_i in the same cycle the counter reaches TIMEOUT counts as success.
  - ack_i while cyc_o = 0 is ignored.
- RESP:
  - tx_valid = 1 with tx_data = status, then each data byte for reads.
  - tx_data holds stable until a transfer (tx_valid & tx_ready). Next byte is presented in the cycle after the transfer.
  - After the last transfer: tx_valid = 0, return to IDLE.
  - tx_ready held low stalls indefinitely.
- rx_valid bytes arriving in BUS or RESP are dropped and do not start a new frame.
- Exactly one Wishbone cycle per complete frame. stb_o is never asserted without cyc_o.

Test Plan:
- Write, ack in 1 cycle: send 57 00 00 08 00 00 00 00 41, slave acks 1 cycle after stb_o.
  - Required: one cycle with adr_o = 32'h00000800, dat_o = 32'h00000041, we_o = 1, sel_o = F.
  - Required: single tx byte 4B, then busy_o = 0.
- Read: send 52 00 00 08 00, slave returns dat_i = 32'hDEADBEEF with ack after 3 wait cycles.
  - Required: we_o = 0; tx bytes 4B DE AD BE EF in order.
- Write timeout: write to an unmapped address, no ack.
  - Required: cyc_o drops exactly TIMEOUT cycles after stb_o rose; tx byte 45.
- Read timeout: read with no ack.
  - Required: tx bytes 45 00 00 00 00.
- Backpressure and noise:
  - Hold tx_ready = 0 for 20 cycles during a read response. Required: tx_data stable, no byte lost.
  - Inject byte 33 in IDLE and bytes during BUS/RESP. Required: all ignored; the next valid frame executes normally.
- Reset mid-frame: assert rst_i after 2 address bytes, then send a full write frame.
  - Required: all outputs return to 0 asynchronously; the new frame yields exactly one write and tx 4B.
